// File: rtl/wm_pkg.sv
// Shared definitions for the washer controller and its front panel:
// washer state codes, panel FSM states and the panel output bundle.
package wm_pkg;

    // Washer controller state codes as presented on wm_state.
    typedef enum logic [2:0] {
        WM_IDLE       = 3'd0,
        WM_FILL_WATER = 3'd1,
        WM_WASH       = 3'd2,
        WM_DRAIN      = 3'd3,
        WM_RINSE      = 3'd4,
        WM_SPIN       = 3'd5,
        WM_DONE       = 3'd6
    } wm_state_e;

    // Panel FSM states.
    typedef enum logic [2:0] {
        P_IDLE   = 3'd0,
        P_ARMED  = 3'd1,
        P_RUN    = 3'd2,
        P_PAUSED = 3'd3,
        P_DONE   = 3'd4,
        P_FAULT  = 3'd5
    } panel_state_e;

    // Everything the FSM drives; registered as one bundle.
    typedef struct packed {
        logic start;
        logic pause;
        logic door_lock;
        logic led_run;
        logic led_pause;
        logic led_done;
        logic led_fault;
        logic buzzer;
    } panel_out_t;

    // Output levels for a given panel state. buzz_win is high during the
    // first part of P_DONE; lock_hold keeps the door locked in P_FAULT
    // while the supply is still bad.
    function automatic panel_out_t panel_outputs(panel_state_e st,
                                                 logic buzz_win,
                                                 logic lock_hold);
        panel_out_t o;
        o = '0;
        case (st)
            P_ARMED: o.door_lock = 1'b1;
            P_RUN: begin
                o.start     = 1'b1;
                o.door_lock = 1'b1;
                o.led_run   = 1'b1;
            end
            P_PAUSED: begin
                o.start     = 1'b1;
                o.pause     = 1'b1;
                o.door_lock = 1'b1;
                o.led_pause = 1'b1;
            end
            P_DONE: begin
                o.led_done = 1'b1;
                o.buzzer   = buzz_win;
            end
            P_FAULT: begin
                o.led_fault = 1'b1;
                o.door_lock = lock_hold;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/wm_panel_ctrl_if.sv
// Panel signal bundle: raw panel/washer inputs toward the controller and
// command/status levels back out. master = environment, slave = controller.
interface wm_panel_ctrl_if;
    logic       btn_start;
    logic       btn_pause;
    logic       door_sw;
    logic       mains_ok;
    logic [2:0] wm_state;

    logic       start;
    logic       pause;
    logic       door_open;
    logic       power_cut;
    logic       door_lock;
    logic       led_run;
    logic       led_pause;
    logic       led_done;
    logic       led_fault;
    logic       buzzer;

    modport master (
        output btn_start, btn_pause, door_sw, mains_ok, wm_state,
        input  start, pause, door_open, power_cut, door_lock,
               led_run, led_pause, led_done, led_fault, buzzer
    );

    modport slave (
        input  btn_start, btn_pause, door_sw, mains_ok, wm_state,
        output start, pause, door_open, power_cut, door_lock,
               led_run, led_pause, led_done, led_fault, buzzer
    );
endinterface

// File: rtl/wm_debounce.sv
// Two-flop synchronizer followed by a counting debouncer. The output level
// flips only after CYCLES consecutive synchronized samples disagree with it;
// any agreeing sample restarts the count.
module wm_debounce #(
    parameter int   CYCLES      = 4,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(CYCLES) + 1;

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous raw input into the clk domain.
    // NOTE: sequential state uses non-blocking assignments so each flop
    // samples the pre-edge value of the one before it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= RESET_LEVEL;
            sync_q2 <= RESET_LEVEL;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive disagreeing samples and accept the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= RESET_LEVEL;
            cnt   <= '0;
        end else if (sync_q2 != level) begin
            if (cnt == CW'(CYCLES - 1)) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/wm_panel_ctrl.sv
// Washing-machine front panel controller: conditions the raw buttons and
// switches, runs the panel FSM and drives registered commands, LEDs and
// the buzzer.
module wm_panel_ctrl
    import wm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCK_SETTLE     = 3,
    parameter int BUZZ_CYCLES     = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    wm_panel_ctrl_if.slave bus
);
    // One dwell counter serves both the lock-settle and buzzer windows.
    localparam int CNT_SPAN = (LOCK_SETTLE > BUZZ_CYCLES) ? LOCK_SETTLE : BUZZ_CYCLES;
    localparam int CW       = $clog2(CNT_SPAN) + 1;

    logic          start_lvl, pause_lvl, door_lvl, mains_lvl;
    logic          start_prev, pause_prev;
    logic          start_evt, pause_evt;
    panel_state_e  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    panel_out_t    outs;
    logic          door_open_q, power_cut_q;

    // Buttons come out of reset as "pressed": a button held through reset
    // must first be seen released before a rising edge can count as a press.
    wm_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db_start (
        .clk(clk), .reset_n(reset_n), .raw(bus.btn_start), .level(start_lvl)
    );
    wm_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db_pause (
        .clk(clk), .reset_n(reset_n), .raw(bus.btn_pause), .level(pause_lvl)
    );
    // Door closed and mains good are the safe idle assumptions.
    wm_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db_door (
        .clk(clk), .reset_n(reset_n), .raw(bus.door_sw), .level(door_lvl)
    );
    wm_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db_mains (
        .clk(clk), .reset_n(reset_n), .raw(bus.mains_ok), .level(mains_lvl)
    );

    // Turn debounced button rises into single-cycle press events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_prev <= 1'b1;
            pause_prev <= 1'b1;
            start_evt  <= 1'b0;
            pause_evt  <= 1'b0;
        end else begin
            start_prev <= start_lvl;
            pause_prev <= pause_lvl;
            start_evt  <= start_lvl & ~start_prev;
            pause_evt  <= pause_lvl & ~pause_prev;
        end
    end

    // Next panel state and dwell count; faults outrank every button.
    // NOTE: every variable gets a default before the branches so no latch
    // is inferred on paths that do not assign it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (!mains_lvl) begin
            state_nxt = P_FAULT;
        end else begin
            case (state)
                P_IDLE:   if (start_evt && door_lvl) state_nxt = P_ARMED;
                P_ARMED: begin
                    if (!door_lvl)                          state_nxt = P_FAULT;
                    else if (cnt == CW'(LOCK_SETTLE - 1))   state_nxt = P_RUN;
                end
                P_RUN: begin
                    if (!door_lvl)                          state_nxt = P_FAULT;
                    else if (bus.wm_state == WM_DONE)       state_nxt = P_DONE;
                    else if (pause_evt)                     state_nxt = P_PAUSED;
                end
                P_PAUSED: begin
                    if (!door_lvl)                          state_nxt = P_FAULT;
                    else if (start_evt || pause_evt)        state_nxt = P_RUN;
                end
                P_DONE:   if (!door_lvl) state_nxt = P_IDLE;
                P_FAULT:  if (start_evt && door_lvl) state_nxt = P_IDLE;
                default:  state_nxt = P_IDLE;
            endcase
        end
        if (state_nxt == state)
            cnt_nxt = (cnt == '1) ? cnt : cnt + CW'(1);
    end

    // Panel state, dwell counter and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= P_IDLE;
            cnt         <= '0;
            outs        <= '0;
            door_open_q <= 1'b0;
            power_cut_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            outs        <= panel_outputs(state_nxt,
                                         cnt_nxt < CW'(BUZZ_CYCLES),
                                         outs.door_lock & ~mains_lvl);
            door_open_q <= ~door_lvl;
            power_cut_q <= ~mains_lvl;
        end
    end

    assign bus.start     = outs.start;
    assign bus.pause     = outs.pause;
    assign bus.door_lock = outs.door_lock;
    assign bus.led_run   = outs.led_run;
    assign bus.led_pause = outs.led_pause;
    assign bus.led_done  = outs.led_done;
    assign bus.led_fault = outs.led_fault;
    assign bus.buzzer    = outs.buzzer;
    assign bus.door_open = door_open_q;
    assign bus.power_cut = power_cut_q;

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Bench for wm_panel_ctrl: a behavioural model predicts the output vector
// after each clock edge into a queue; a monitor compares it on the falling
// edge. Directed sequences add absolute timing checks.
module tb_wm_panel_ctrl;
    localparam int DEB   = 4;
    localparam int LOCK  = 3;
    localparam int BUZZ  = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       raw_start = 1'b0;
    logic       raw_pause = 1'b0;
    logic       raw_door  = 1'b1;
    logic       raw_mains = 1'b1;
    logic [2:0] raw_wm    = 3'd0;

    wm_panel_ctrl_if bus();
    assign bus.btn_start = raw_start;
    assign bus.btn_pause = raw_pause;
    assign bus.door_sw   = raw_door;
    assign bus.mains_ok  = raw_mains;
    assign bus.wm_state  = raw_wm;

    wm_panel_ctrl #(.DEBOUNCE_CYCLES(DEB), .LOCK_SETTLE(LOCK), .BUZZ_CYCLES(BUZZ)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // {start,pause,door_open,power_cut,door_lock,led_run,led_pause,led_done,led_fault,buzzer}
    function automatic logic [9:0] dut_vec();
        return {bus.start, bus.pause, bus.door_open, bus.power_cut, bus.door_lock,
                bus.led_run, bus.led_pause, bus.led_done, bus.led_fault, bus.buzzer};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %b, expected %b", name, cycle, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ARMED, M_RUN, M_PAUSED, M_DONE, M_FAULT} mstate_e;
    mstate_e    m_state;
    int         m_edge, m_entry;
    bit         m_lock;
    bit         lvl[4];          // 0 start, 1 pause, 2 door closed, 3 mains good
    int         run[4];
    bit [1:0]   hist[4];         // raw samples one ([0]) and two ([1]) edges old
    bit         evs_q[$], evp_q[$];
    logic [9:0] m_out;
    logic [9:0] exp_q[$];

    task automatic model_reset();
        m_state = M_IDLE; m_edge = 0; m_entry = 0; m_lock = 0; m_out = '0;
        // A button seen at reset counts as held until observed released.
        for (int i = 0; i < 4; i++) begin
            lvl[i] = 1'b1; run[i] = 0; hist[i] = 2'b11;
        end
        evs_q = '{1'b0, 1'b0};
        evp_q = '{1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit      r[4];
        bit      rose[4];
        bit      ev_s, ev_p, closed, good, s;
        mstate_e nxt;
        r = '{raw_start, raw_pause, raw_door, raw_mains};
        m_edge++;
        // A debounced press reaches the panel logic two edges after the rise.
        ev_s = evs_q.pop_front();
        ev_p = evp_q.pop_front();
        closed = lvl[2];
        good   = lvl[3];
        nxt = m_state;
        if (!good) nxt = M_FAULT;
        else case (m_state)
            M_IDLE:   if (ev_s && closed) nxt = M_ARMED;
            M_ARMED:  if (!closed) nxt = M_FAULT;
                      else if (m_edge - m_entry == LOCK) nxt = M_RUN;
            M_RUN:    if (!closed) nxt = M_FAULT;
                      else if (raw_wm == 3'd6) nxt = M_DONE;
                      else if (ev_p) nxt = M_PAUSED;
            M_PAUSED: if (!closed) nxt = M_FAULT;
                      else if (ev_s || ev_p) nxt = M_RUN;
            M_DONE:   if (!closed) nxt = M_IDLE;
            M_FAULT:  if (ev_s && closed) nxt = M_IDLE;
            default:  nxt = M_IDLE;
        endcase
        if (nxt != m_state) m_entry = m_edge;
        m_state = nxt;
        m_out = '0;
        m_out[7] = !closed;
        m_out[6] = !good;
        case (nxt)
            M_ARMED:  m_out[5] = 1'b1;
            M_RUN:    begin m_out[9] = 1'b1; m_out[5] = 1'b1; m_out[4] = 1'b1; end
            M_PAUSED: begin m_out[9] = 1'b1; m_out[8] = 1'b1; m_out[5] = 1'b1; m_out[3] = 1'b1; end
            M_DONE:   begin m_out[2] = 1'b1; m_out[0] = (m_edge - m_entry) < BUZZ; end
            M_FAULT:  begin m_out[1] = 1'b1; m_out[5] = m_lock && !good; end
            default:  ;
        endcase
        m_lock = m_out[5];
        for (int i = 0; i < 4; i++) begin
            rose[i] = 1'b0;
            s = hist[i][1];
            hist[i] = {hist[i][0], r[i]};
            if (s != lvl[i]) begin
                run[i]++;
                if (run[i] == DEB) begin
                    lvl[i] = s; run[i] = 0; rose[i] = s;
                end
            end else begin
                run[i] = 0;
            end
        end
        evs_q.push_back(rose[0]);
        evp_q.push_back(rose[1]);
    endtask

    // One clock: predict at the rising edge, return on the falling edge.
    task automatic step();
        @(posedge clk);
        cycle++;
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step();
        end
        exp_q.push_back(m_out);
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard monitor.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", dut_vec(), e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int buzz_cnt;
        int h_s, h_p, h_d, h_m, h_w;
        model_reset();
        #1 check("reset outputs low", dut_vec(), 10'd0);
        cyc(3);
        reset_n = 1'b1;
        cyc(12);

        // Clean start press held 20 cycles: lock after edge 7, start after edge 10.
        raw_start = 1'b1;
        cyc(7);  check("lock before edge 7", bus.door_lock, 1'b0);
        cyc(1);  check("lock at edge 7", bus.door_lock, 1'b1);
        cyc(2);  check("start before edge 10", bus.start, 1'b0);
        cyc(1);  check("start at edge 10", bus.start, 1'b1);
        cyc(9);
        raw_start = 1'b0;
        cyc(10);
        check("run after press", {bus.led_run, bus.start}, 2'b11);

        // Unused washer code is not DONE.
        raw_wm = 3'd7;
        cyc(5);
        check("code 7 stays run", {bus.led_run, bus.led_done}, 2'b10);
        raw_wm = 3'd0;

        // Pause and resume.
        raw_pause = 1'b1; cyc(10);
        check("paused", {bus.pause, bus.led_pause, bus.start}, 3'b111);
        raw_pause = 1'b0; cyc(10);
        raw_pause = 1'b1; cyc(10);
        check("resumed", {bus.pause, bus.led_run, bus.start}, 3'b011);
        raw_pause = 1'b0; cyc(10);

        // Cycle done: buzzer for exactly BUZZ cycles, door unlocked.
        raw_wm = 3'd6;
        buzz_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            buzz_cnt += int'(bus.buzzer);
        end
        check("buzzer length", 10'(buzz_cnt), 10'(BUZZ));
        check("done outputs", {bus.led_done, bus.door_lock, bus.start}, 3'b100);
        raw_wm = 3'd0;
        raw_door = 1'b0; cyc(10);
        check("door open to idle", {bus.led_done, bus.door_open, bus.led_fault}, 3'b010);
        raw_door = 1'b1; cyc(10);

        // Bouncing start button: no event until stable, then normal latency.
        for (int i = 0; i < 12; i++) begin
            raw_start = ((i / 2) % 2) == 0;
            step();
        end
        check("no lock while bouncing", bus.door_lock, 1'b0);
        raw_start = 1'b1;
        cyc(7);  check("bounce lock before edge 7", bus.door_lock, 1'b0);
        cyc(1);  check("bounce lock at edge 7", bus.door_lock, 1'b1);
        cyc(10);
        raw_start = 1'b0;
        cyc(6);

        // Mains drop in run: fault 6 cycles after drop, lock held while bad.
        raw_mains = 1'b0;
        cyc(6);  check("still running at edge 5", {bus.start, bus.power_cut}, 2'b10);
        cyc(1);  check("fault at edge 6",
                       {bus.start, bus.power_cut, bus.led_fault, bus.door_lock}, 4'b0111);
        cyc(3);
        raw_mains = 1'b1;
        cyc(12);
        check("lock released on good mains", {bus.door_lock, bus.power_cut, bus.led_fault}, 3'b001);
        raw_start = 1'b1; cyc(8);
        raw_start = 1'b0; cyc(6);
        check("fault cleared to idle", {bus.led_fault, bus.start, bus.door_lock}, 3'b000);

        // Reach pause, then asynchronous reset with start held through it.
        raw_start = 1'b1; cyc(8);
        raw_start = 1'b0; cyc(8);
        raw_pause = 1'b1; cyc(8);
        raw_pause = 1'b0; cyc(4);
        check("paused before reset", {bus.pause, bus.start, bus.door_lock}, 3'b111);
        raw_start = 1'b1;
        #1 reset_n = 1'b0;
        #1 check("async reset clears outputs", dut_vec(), 10'd0);
        cyc(3);
        reset_n = 1'b1;
        cyc(20);
        check("held start ignored after reset", {bus.start, bus.door_lock}, 2'b00);
        raw_start = 1'b0;
        cyc(10);

        // Randomized phase.
        h_s = 0; h_p = 0; h_d = 0; h_m = 0; h_w = 0;
        for (int i = 0; i < 3000; i++) begin
            if (h_s == 0) begin raw_start = ($urandom_range(0, 2) == 0); h_s = $urandom_range(1, 12); end
            if (h_p == 0) begin raw_pause = ($urandom_range(0, 3) == 0); h_p = $urandom_range(1, 12); end
            if (h_d == 0) begin
                raw_door = ($urandom_range(0, 9) != 0);
                h_d = raw_door ? $urandom_range(10, 80) : $urandom_range(1, 20);
            end
            if (h_m == 0) begin
                raw_mains = ($urandom_range(0, 14) != 0);
                h_m = raw_mains ? $urandom_range(20, 150) : $urandom_range(1, 15);
            end
            if (h_w == 0) begin raw_wm = 3'($urandom_range(0, 7)); h_w = $urandom_range(1, 25); end
            h_s--; h_p--; h_d--; h_m--; h_w--;
            step();
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", 10'(exp_q.size()), 10'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
